alu_p_accum_simd: RTL

ALU_P_ACCUM_SIMD -- requirements
Module: alu_p_accum_simd

---
 rtl/alu_p_accum_simd.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_p_accum_simd.sv
// Accumulator back-end for a SIMD ALU. It collects ACC_LEN beats of S into P and feeds P back as P_fb.
// It keeps sticky overflow flags for each lane. Defining ALU_ACC_SATURATE_EN makes overflowing lanes saturate to all-ones.
module alu_p_accum_simd #(
  parameter int unsigned ACC_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  USE_SIMD,
  input  logic [31:0] S,
  input  logic [7:0]  result_SIMD_carry_out,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] P_fb,
  output logic [31:0] P,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  overflow,
  output logic [7:0]  acc_count
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SLICE_N = 8;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   p_q, p_d;
  logic [SLICE_N-1:0]  overflow_q, overflow_d;
  logic [CNT_W-1:0]    acc_count_q, acc_count_d;
  logic [1:0]          mode_q, mode_d;

  logic                accept_c;
  logic [1:0]          eff_mode_c;
  logic [SLICE_N-1:0]  ov_acc_c;
  logic [DATA_W-1:0]   p_next_c;

  // Top slice of every lane group for a given SIMD mode
  function automatic logic [SLICE_N-1:0] group_tops(input logic [1:0] m);
    logic [SLICE_N-1:0] r;
    case (m)
      2'b00:   r = 8'h80;
      2'b01:   r = 8'h88;
      2'b10:   r = 8'hAA;
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

`ifdef ALU_ACC_SATURATE_EN
  // Give every slice the overflow flag of the top slice in its lane group
  function automatic logic [SLICE_N-1:0] spread_tops(input logic [1:0] m,
                                                     input logic [SLICE_N-1:0] flags);
    logic [SLICE_N-1:0] r;
    logic [2:0]         gmask;
    logic [2:0]         top;
    case (m)
      2'b00:   gmask = 3'd7;
      2'b01:   gmask = 3'd3;
      2'b10:   gmask = 3'd1;
      default: gmask = 3'd0;
    endcase
    r = '0;
    for (int j = 0; j < int'(SLICE_N); j++) begin
      top  = 3'(j) | gmask;
      r[j] = flags[top];
    end
    return r;
  endfunction
`endif

  assign accept_c   = in_valid && (state_q != HOLD);
  assign in_ready   = (state_q != HOLD);
  assign out_valid  = (state_q == HOLD);
  assign P_fb       = (state_q == IDLE) ? '0 : p_q;
  assign P          = p_q;
  assign overflow   = overflow_q;
  assign acc_count  = acc_count_q;

  // An IDLE accept uses the incoming mode and starts from clear flags.
  always_comb begin
    eff_mode_c = (state_q == IDLE) ? USE_SIMD : mode_q;
    ov_acc_c   = ((state_q == IDLE) ? '0 : overflow_q)
               | (group_tops(eff_mode_c) & result_SIMD_carry_out);
    p_next_c   = S;
`ifdef ALU_ACC_SATURATE_EN
    begin
      logic [SLICE_N-1:0] sat_slices;
      sat_slices = spread_tops(eff_mode_c, ov_acc_c);
      for (int j = 0; j < int'(SLICE_N); j++) begin
        if (sat_slices[j]) p_next_c[4*j +: 4] = 4'hF;
      end
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    overflow_d  = overflow_q;
    acc_count_d = acc_count_q;
    mode_d      = mode_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          mode_d      = USE_SIMD;
          overflow_d  = ov_acc_c;
          p_d         = p_next_c;
          acc_count_d = CNT_W'(1);
          state_d     = (ACC_LEN == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept_c) begin
          overflow_d  = ov_acc_c;
          p_d         = p_next_c;
          acc_count_d = acc_count_q + CNT_W'(1);
          if (acc_count_d == CNT_W'(ACC_LEN)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      p_q         <= '0;
      overflow_q  <= '0;
      acc_count_q <= '0;
      mode_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      overflow_q  <= overflow_d;
      acc_count_q <= acc_count_d;
      mode_q      <= mode_d;
    end
  end

endmodule
